jtframe_sdram_rd: RTL

Read-only single-bank SDRAM controller. It sits directly downstream of the ROM slot requesters and serves their sdram_req/sdram_addr handshake with ack, data_dst, data_rdy and data_read.
It drives the SDRAM pins itself and handles power-up initialisation and periodic auto-refresh.
It is used in cores whose SDRAM contents are loaded externally, so it issues no write commands.

---
 rtl/jtframe_sdram_pkg.sv | 26 ++
 rtl/jtframe_sdram_rfsh.sv | 34 +++
 rtl/jtframe_sdram_rd.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the read-only SDRAM controller: command encodings,
// FSM states and the mode-register word builder.
`timescale 1ns/1ps
package jtframe_sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    typedef enum logic [2:0] {
        INIT, PRE, RF, MRS, IDLE, ACT, RD, WAIT
    } state_t;

    // Burst length 1, sequential, single-location write bursts, given CAS latency
    function automatic logic [12:0] mode_reg(input int cl);
        logic [12:0] m;
        m      = 13'h200;
        m[6:4] = 3'(cl);
        return m;
    endfunction

endpackage

// File: rtl/jtframe_sdram_rfsh.sv
// Auto-refresh period timer. Raises pending on every wrap of the period
// counter; a wrap while already pending does not queue a second refresh.
`timescale 1ns/1ps
module jtframe_sdram_rfsh #(
    parameter int RFSH_PERIOD = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic pending
);

    localparam int CW = $clog2(RFSH_PERIOD + 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = en && (cnt == CW'(RFSH_PERIOD - 1));

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            if (en) cnt <= wrap ? '0 : cnt + 1'b1;
            // A wrap coinciding with a clear must win, or that refresh is lost
            pending <= (pending & ~clr) | wrap;
        end
    end

endmodule

// File: rtl/jtframe_sdram_rd.sv
// Read-only single-bank SDRAM controller: power-up init, periodic refresh and
// single-word reads with auto-precharge on behalf of the ROM slot requesters.
`timescale 1ns/1ps
module jtframe_sdram_rd
    import jtframe_sdram_pkg::*;
#(
    parameter int SDRAMW      = 22,
    parameter int TRCD        = 2,
    parameter int CL          = 2,
    parameter int TRC         = 7,
    parameter int TRP         = 2,
    parameter int INIT_WAIT   = 10000,
    parameter int RFSH_PERIOD = 780
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_req,
    input  logic [SDRAMW-1:0] sdram_addr,
    output logic              sdram_ack,
    output logic              data_dst,
    output logic              data_rdy,
    output logic [15:0]       data_read,
    output logic              init_done,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [1:0]        sdram_ba,
    output logic [12:0]       sdram_a,
    output logic [1:0]        sdram_dqm,
    input  logic [15:0]       sdram_din
);

    // ACTIVE of one access to the next ACTIVE/REFRESH
    localparam int T_RDP = TRCD + CL + 1 + TRP;
    localparam int T_ACC = (TRC > T_RDP) ? TRC : T_RDP;
    localparam int WMAX  = (INIT_WAIT > T_ACC) ? INIT_WAIT : T_ACC;
    localparam int WW    = $clog2(WMAX + 1);

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic            second_ref, second_nxt;
    logic [8:0]      col_q;
    logic            rfsh_pending;
    logic            wait_zero, go_idle, do_ref, do_act;
    logic [3:0]      cmd_nxt;
    logic [12:0]     a_nxt;
    logic [1:0]      dqm_nxt;
    logic            ack_nxt, dst_nxt, done_nxt;

    jtframe_sdram_rfsh #(.RFSH_PERIOD(RFSH_PERIOD)) u_rfsh (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (init_done),
        .clr     (do_ref),
        .pending (rfsh_pending)
    );

    // A wait counter loaded with N-1 places the next command exactly N cycles
    // after the current one; the arbiter also runs on the last wait cycle.
    assign wait_zero = (wait_cnt == '0);
    assign go_idle   = init_done && ((state == IDLE) ||
                       (wait_zero && (state == RF || state == WAIT)));
    assign do_ref    = go_idle && rfsh_pending;
    assign do_act    = go_idle && !rfsh_pending && sdram_req;
    assign sdram_ba  = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            wait_cnt   <= WW'(INIT_WAIT);
            second_ref <= 1'b0;
            col_q      <= '0;
            sdram_cke  <= 1'b0;
            sdram_cmd  <= CMD_NOP;
            sdram_a    <= '0;
            sdram_dqm  <= 2'b11;
            sdram_ack  <= 1'b0;
            data_dst   <= 1'b0;
            data_rdy   <= 1'b0;
            data_read  <= '0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            second_ref <= second_nxt;
            if (do_act) col_q <= sdram_addr[8:0];
            sdram_cke  <= 1'b1;
            sdram_cmd  <= cmd_nxt;
            sdram_a    <= a_nxt;
            sdram_dqm  <= dqm_nxt;
            sdram_ack  <= ack_nxt;
            data_dst   <= dst_nxt;
            data_rdy   <= data_dst;
            if (data_dst) data_read <= sdram_din;
            init_done  <= done_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nxt  = state;
        wait_nxt   = wait_zero ? '0 : wait_cnt - 1'b1;
        second_nxt = second_ref;
        case (state)
            INIT: if (wait_zero) begin
                state_nxt = PRE;
                wait_nxt  = WW'(TRP - 1);
            end
            PRE: if (wait_zero) begin
                state_nxt = RF;
                wait_nxt  = WW'(TRC - 1);
            end
            RF: if (!init_done && wait_zero) begin
                if (!second_ref) begin
                    second_nxt = 1'b1;
                    wait_nxt   = WW'(TRC - 1);
                end else begin
                    state_nxt = MRS;
                    wait_nxt  = WW'(2);
                end
            end
            MRS: if (wait_zero) state_nxt = IDLE;
            ACT: if (wait_zero) begin
                state_nxt = RD;
                wait_nxt  = WW'(CL - 1);
            end
            RD: if (wait_zero) begin
                state_nxt = WAIT;
                wait_nxt  = WW'(T_ACC - TRCD - CL - 1);
            end
            default: ;
        endcase
        if (go_idle) begin
            state_nxt = IDLE;
            if (do_ref) begin
                state_nxt = RF;
                wait_nxt  = WW'(TRC - 1);
            end else if (do_act) begin
                state_nxt = ACT;
                wait_nxt  = WW'(TRCD - 1);
            end
        end
    end

    always_comb begin
        cmd_nxt  = CMD_NOP;
        a_nxt    = sdram_a;
        dqm_nxt  = sdram_dqm;
        ack_nxt  = 1'b0;
        dst_nxt  = 1'b0;
        done_nxt = init_done;
        case (state)
            INIT: if (wait_zero) begin
                cmd_nxt = CMD_PRE;
                a_nxt   = 13'h400;
            end
            PRE: if (wait_zero) cmd_nxt = CMD_REF;
            RF: if (!init_done && wait_zero) begin
                if (!second_ref) begin
                    cmd_nxt = CMD_REF;
                end else begin
                    cmd_nxt = CMD_MRS;
                    a_nxt   = mode_reg(CL);
                end
            end
            MRS: if (wait_zero) begin
                done_nxt = 1'b1;
                dqm_nxt  = 2'b00;
            end
            ACT: if (wait_zero) begin
                cmd_nxt = CMD_RD;
                a_nxt   = {2'b00, 1'b1, 1'b0, col_q};
            end
            RD: if (wait_zero) dst_nxt = 1'b1;
            default: ;
        endcase
        if (do_ref) begin
            cmd_nxt = CMD_REF;
        end else if (do_act) begin
            cmd_nxt = CMD_ACT;
            a_nxt   = 13'(sdram_addr >> 9);
            ack_nxt = 1'b1;
        end
    end

endmodule
